// File: rtl/axis_cross_spectrum.sv
// axis_cross_spectrum
//   Three-stage pipelined AXI4-Stream complex multiplier forming the per-bin
//   cross-spectrum X_A * conj(X_B). Channel B arrives already conjugated.
//
//   Build option: define CMULT_SAT_EN to saturate each 32-bit output
//   component instead of wrapping.
//
//   Ports
//     s00_axis_aclk / s00_axis_aresetn  clock, async active-low reset
//     s00_axis_*   channel A in   tdata = {re[63:32], im[31:0]}, tlast
//     s01_axis_*   channel B in   tdata = {im[63:32], re[31:0]} (conjugated), tlast
//     m00_axis_*   product out    tdata = {re[63:32], im[31:0]}, tlast
//     frame_err    sticky frame alignment error
//     err_clr      synchronous clear of frame_err (a same-cycle error wins)
module axis_cross_spectrum #(
  parameter int PROD_SHIFT = 16,
  parameter int FRAME_LEN  = 4096,
  parameter int CNT_W      = 12
) (
  input  logic        s00_axis_aclk,
  input  logic        s00_axis_aresetn,
  input  logic        s00_axis_tvalid,
  output logic        s00_axis_tready,
  input  logic [63:0] s00_axis_tdata,
  input  logic        s00_axis_tlast,
  input  logic        s01_axis_tvalid,
  output logic        s01_axis_tready,
  input  logic [63:0] s01_axis_tdata,
  input  logic        s01_axis_tlast,
  output logic        m00_axis_tvalid,
  input  logic        m00_axis_tready,
  output logic [63:0] m00_axis_tdata,
  output logic        m00_axis_tlast,
  output logic        frame_err,
  input  logic        err_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_LEN - 1);

  logic vld1, vld2, vld3;
  logic rdy1, rdy2, rdy3;
  logic accept;

  // Combinational ready chain: a stage may load whenever it is empty or the
  // stage after it is draining this cycle.
  assign rdy3 = !vld3 || m00_axis_tready;
  assign rdy2 = !vld2 || rdy3;
  assign rdy1 = !vld1 || rdy2;

  // Join: both channels are consumed together. Gating with the reset keeps
  // both treadys low while reset is held, even though the pipeline is empty.
  assign accept          = s00_axis_aresetn && s00_axis_tvalid && s01_axis_tvalid && rdy1;
  assign s00_axis_tready = accept;
  assign s01_axis_tready = accept;

  // Stage 1: operand registers
  logic [31:0] ar, ai, br, bi;
  logic        last1;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      vld1  <= 1'b0;
      ar    <= '0;
      ai    <= '0;
      br    <= '0;
      bi    <= '0;
      last1 <= 1'b0;
    end else if (rdy1) begin
      vld1 <= accept;
      if (accept) begin
        ar    <= s00_axis_tdata[63:32];
        ai    <= s00_axis_tdata[31:0];
        bi    <= s01_axis_tdata[63:32];
        br    <= s01_axis_tdata[31:0];
        last1 <= s00_axis_tlast;
      end
    end
  end

  // Stage 2: four partial products. The low 64 bits of a product of
  // sign-extended operands equal the exact signed 32x32 product.
  function automatic logic [63:0] sx64(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  logic [63:0] p_rr, p_ii, p_ir, p_ri;
  logic        last2;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      vld2  <= 1'b0;
      p_rr  <= '0;
      p_ii  <= '0;
      p_ir  <= '0;
      p_ri  <= '0;
      last2 <= 1'b0;
    end else if (rdy2) begin
      vld2 <= vld1;
      if (vld1) begin
        p_rr  <= sx64(ar) * sx64(br);
        p_ii  <= sx64(ai) * sx64(bi);
        p_ir  <= sx64(ai) * sx64(br);
        p_ri  <= sx64(ar) * sx64(bi);
        last2 <= last1;
      end
    end
  end

  // Stage 3 combine: 65 bits so the sum of two full-scale products cannot
  // overflow before the shift.
  logic signed [64:0] re_full, im_full, re_sh, im_sh;
  logic        [31:0] re_q, im_q;

  always_comb begin
    re_full = {p_rr[63], p_rr} - {p_ii[63], p_ii};
    im_full = {p_ir[63], p_ir} + {p_ri[63], p_ri};
    re_sh   = re_full >>> PROD_SHIFT;
    im_sh   = im_full >>> PROD_SHIFT;
  end

`ifdef CMULT_SAT_EN
  // In range only when bits [64:31] are all copies of the sign.
  function automatic logic [31:0] sat32(input logic signed [64:0] v);
    if (v[64:31] == {34{v[64]}})
      return v[31:0];
    return v[64] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  assign re_q = sat32(re_sh);
  assign im_q = sat32(im_sh);
`else
  // Two's-complement wrap: the upper bits are intentionally discarded.
  logic unused_hi;
  assign re_q      = re_sh[31:0];
  assign im_q      = im_sh[31:0];
  assign unused_hi = ^{re_sh[64:32], im_sh[64:32]};
`endif

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      vld3           <= 1'b0;
      m00_axis_tdata <= '0;
      m00_axis_tlast <= 1'b0;
    end else if (rdy3) begin
      vld3 <= vld2;
      if (vld2) begin
        m00_axis_tdata <= {re_q, im_q};
        m00_axis_tlast <= last2;
      end
    end
  end

  assign m00_axis_tvalid = vld3;

  // Bin counter and frame alignment check. Any beat carrying s00 tlast
  // restarts the count, so a misaligned frame resynchronises on its own.
  logic [CNT_W-1:0] cnt;
  logic             at_end, err_set;

  assign at_end  = (cnt == CNT_MAX);
  assign err_set = accept && ((s00_axis_tlast != s01_axis_tlast) ||
                              (s00_axis_tlast && !at_end) ||
                              (!s00_axis_tlast && at_end));

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      if (accept)
        cnt <= (s00_axis_tlast || at_end) ? '0 : cnt + CNT_W'(1);
      if (err_set)
        frame_err <= 1'b1;
      else if (err_clr)
        frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_cross_spectrum.sv
module tb_axis_cross_spectrum;

  localparam int PROD_SHIFT = 0;
  localparam int FRAME_LEN  = 4096;
  localparam int CNT_W      = 12;

  logic        s00_axis_aclk = 1'b0;
  logic        s00_axis_aresetn = 1'b0;
  logic        s00_axis_tvalid = 1'b0;
  logic        s00_axis_tready;
  logic [63:0] s00_axis_tdata = '0;
  logic        s00_axis_tlast = 1'b0;
  logic        s01_axis_tvalid = 1'b0;
  logic        s01_axis_tready;
  logic [63:0] s01_axis_tdata = '0;
  logic        s01_axis_tlast = 1'b0;
  logic        m00_axis_tvalid;
  logic        m00_axis_tready = 1'b1;
  logic [63:0] m00_axis_tdata;
  logic        m00_axis_tlast;
  logic        frame_err;
  logic        err_clr = 1'b0;

  axis_cross_spectrum #(
    .PROD_SHIFT(PROD_SHIFT),
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) dut (
    .s00_axis_aclk   (s00_axis_aclk),
    .s00_axis_aresetn(s00_axis_aresetn),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tready (s00_axis_tready),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tlast  (s00_axis_tlast),
    .s01_axis_tvalid (s01_axis_tvalid),
    .s01_axis_tready (s01_axis_tready),
    .s01_axis_tdata  (s01_axis_tdata),
    .s01_axis_tlast  (s01_axis_tlast),
    .m00_axis_tvalid (m00_axis_tvalid),
    .m00_axis_tready (m00_axis_tready),
    .m00_axis_tdata  (m00_axis_tdata),
    .m00_axis_tlast  (m00_axis_tlast),
    .frame_err       (frame_err),
    .err_clr         (err_clr)
  );

  always #5 s00_axis_aclk = ~s00_axis_aclk;

  int n_pass = 0;
  int n_total = 0;
  int prot_err = 0;
  int fail_prints = 0;
  int out_cnt = 0;
  int last_cnt = 0;
  bit rand_rdy = 1'b0;

  logic [64:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Reference model: exact integer arithmetic on wide signed values.
  function automatic logic [31:0] reduce(input logic signed [127:0] v);
    logic signed [127:0] s;
    s = v >>> PROD_SHIFT;
`ifdef CMULT_SAT_EN
    if (s > 128'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (s < -128'sh8000_0000) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] ar, ai, br, bi;
    ar = {{96{a[63]}}, a[63:32]};
    ai = {{96{a[31]}}, a[31:0]};
    bi = {{96{b[63]}}, b[63:32]};
    br = {{96{b[31]}}, b[31:0]};
    return {reduce(ar * br - ai * bi), reduce(ai * br + ar * bi)};
  endfunction

  // Scoreboard and protocol monitor, sampled mid-cycle.
  bit          stall_q = 1'b0;
  logic [64:0] stall_val;
  always @(negedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      exp_q.delete();
      stall_q = 1'b0;
      if (s00_axis_tready || s01_axis_tready) prot_err++;
    end else begin
      if (s00_axis_tready != s01_axis_tready) prot_err++;
      if (s00_axis_tready && !(s00_axis_tvalid && s01_axis_tvalid)) prot_err++;
      if (stall_q && !(m00_axis_tvalid && {m00_axis_tlast, m00_axis_tdata} == stall_val)) prot_err++;
      stall_q   = m00_axis_tvalid && !m00_axis_tready;
      stall_val = {m00_axis_tlast, m00_axis_tdata};
      if (s00_axis_tvalid && s00_axis_tready)
        exp_q.push_back({s00_axis_tlast, model(s00_axis_tdata, s01_axis_tdata)});
      if (m00_axis_tvalid && m00_axis_tready) begin
        logic [64:0] e;
        out_cnt++;
        if (m00_axis_tlast) last_cnt++;
        n_total++;
        if (exp_q.size() == 0) begin
          if (fail_prints < 20) $display("FAIL scoreboard: got unexpected output %h, expected none", m00_axis_tdata);
          fail_prints++;
        end else begin
          e = exp_q.pop_front();
          if ({m00_axis_tlast, m00_axis_tdata} === e) n_pass++;
          else begin
            if (fail_prints < 20) $display("FAIL scoreboard: got %h, expected %h", {m00_axis_tlast, m00_axis_tdata}, e);
            fail_prints++;
          end
        end
      end
    end
  end

  always @(posedge s00_axis_aclk) begin
    if (rand_rdy) begin
      #1;
      m00_axis_tready = ($urandom_range(0, 3) != 0);
    end
  end

  // All drives happen 1 time unit after the rising edge.
  task automatic set_in(input logic [63:0] a, input logic [63:0] b, input logic la, input logic lb);
    s00_axis_tdata  = a;
    s01_axis_tdata  = b;
    s00_axis_tlast  = la;
    s01_axis_tlast  = lb;
    s00_axis_tvalid = 1'b1;
    s01_axis_tvalid = 1'b1;
  endtask

  task automatic drop();
    s00_axis_tvalid = 1'b0;
    s01_axis_tvalid = 1'b0;
    s00_axis_tlast  = 1'b0;
    s01_axis_tlast  = 1'b0;
  endtask

  // Present one beat and return just after the edge that accepts it.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic la, input logic lb,
                      output int waits);
    bit acc;
    acc   = 1'b0;
    waits = 0;
    set_in(a, b, la, lb);
    for (int k = 0; k < 200; k++) begin
      @(negedge s00_axis_aclk);
      acc = s00_axis_tready;
      waits = k + 1;
      @(posedge s00_axis_aclk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout: got no tready, expected acceptance within 200 cycles");
    end
  endtask

  task automatic idle(input int n);
    drop();
    repeat (n) begin
      @(posedge s00_axis_aclk);
      #1;
    end
  endtask

  // Called just after the accepting edge: cycles until m00 tvalid and the data.
  task automatic measure(output logic [63:0] d, output int lat);
    lat = 0;
    d   = '0;
    for (int k = 0; k < 10; k++) begin
      lat++;
      @(negedge s00_axis_aclk);
      if (m00_axis_tvalid) break;
    end
    d = m00_axis_tdata;
    @(posedge s00_axis_aclk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      @(posedge s00_axis_aclk);
      #1;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    s00_axis_aresetn = 1'b0;
    drop();
    repeat (2) begin
      @(posedge s00_axis_aclk);
      #1;
    end
    s00_axis_aresetn = 1'b1;
    @(posedge s00_axis_aclk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vec[7];

  initial begin
    int          w, lat, err_acc;
    logic [63:0] d;

    vec[0] = '{64'h00000003_00000004, 64'hFFFFFFFE_00000001, 64'h0000000B_FFFFFFFE};
    vec[2] = '{64'hFFFFFFFB_00000002, 64'h00000003_FFFFFFFC, 64'h0000000E_FFFFFFE9};
    vec[5] = '{64'h00000001_00000001, 64'h00000001_00000001, 64'h00000000_00000002};
`ifdef CMULT_SAT_EN
    vec[1] = '{64'h7FFFFFFF_00000000, 64'h00000000_7FFFFFFF, 64'h7FFFFFFF_00000000};
    vec[3] = '{64'h80000000_00000000, 64'h00000000_80000000, 64'h7FFFFFFF_00000000};
    vec[4] = '{64'h00000000_80000000, 64'h80000000_00000000, 64'h80000000_00000000};
    vec[6] = '{64'h7FFFFFFF_7FFFFFFF, 64'h7FFFFFFF_7FFFFFFF, 64'h00000000_7FFFFFFF};
`else
    vec[1] = '{64'h7FFFFFFF_00000000, 64'h00000000_7FFFFFFF, 64'h00000001_00000000};
    vec[3] = '{64'h80000000_00000000, 64'h00000000_80000000, 64'h00000000_00000000};
    vec[4] = '{64'h00000000_80000000, 64'h80000000_00000000, 64'h00000000_00000000};
    vec[6] = '{64'h7FFFFFFF_7FFFFFFF, 64'h7FFFFFFF_7FFFFFFF, 64'h00000000_00000002};
`endif

    // Reset state, with both input valids high during reset.
    s00_axis_tvalid = 1'b1;
    s01_axis_tvalid = 1'b1;
    repeat (2) @(posedge s00_axis_aclk);
    #1;
    check("rst_s00_tready", 64'(s00_axis_tready), 64'd0);
    check("rst_s01_tready", 64'(s01_axis_tready), 64'd0);
    check("rst_m00_tvalid", 64'(m00_axis_tvalid), 64'd0);
    check("rst_m00_tdata", m00_axis_tdata, 64'd0);
    check("rst_m00_tlast", 64'(m00_axis_tlast), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    drop();
    s00_axis_aresetn = 1'b1;
    @(posedge s00_axis_aclk);
    #1;

    // Fixed vectors: value and 3-cycle latency.
    for (int i = 0; i < 7; i++) begin
      send(vec[i].a, vec[i].b, 1'b0, 1'b0, w);
      drop();
      measure(d, lat);
      check($sformatf("vec%0d_data", i), d, vec[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
    end

    // Join skew: s01 valid alone for 5 cycles.
    err_acc = 0;
    s01_axis_tvalid = 1'b1;
    s01_axis_tdata  = 64'h00000005_00000002;
    repeat (5) begin
      @(negedge s00_axis_aclk);
      if (s00_axis_tready || s01_axis_tready) err_acc++;
      @(posedge s00_axis_aclk);
      #1;
    end
    check("skew_no_tready", 64'(err_acc), 64'd0);
    send(64'h00000007_FFFFFFFD, 64'h00000005_00000002, 1'b0, 1'b0, w);
    drop();
    check("skew_accept_first_cycle", 64'(w), 64'd1);
    measure(d, lat);
    check("skew_latency", 64'(lat), 64'd3);
    // re = 7*2 - (-3)*5 = 29, im = (-3)*2 + 7*5 = 29
    check("skew_data", d, 64'h0000001D_0000001D);

    // Full pipeline with output stalled: inputs blocked, then released at once.
    m00_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) send(rnd64(), rnd64(), 1'b0, 1'b0, w);
    set_in(rnd64(), rnd64(), 1'b0, 1'b0);
    err_acc = 0;
    repeat (3) begin
      @(negedge s00_axis_aclk);
      if (s00_axis_tready || s01_axis_tready) err_acc++;
      @(posedge s00_axis_aclk);
      #1;
    end
    check("full_stall_blocks", 64'(err_acc), 64'd0);
    m00_axis_tready = 1'b1;
    @(negedge s00_axis_aclk);
    check("stall_release_tready", 64'({s00_axis_tready, s01_axis_tready}), 64'd3);
    @(posedge s00_axis_aclk);
    #1;
    drop();
    wait_drain();

    // Frame alignment.
    do_reset();
    for (int i = 0; i < 100; i++) send(rnd64(), rnd64(), 1'b0, 1'b0, w);
    check("align_err_before", 64'(frame_err), 64'd0);
    send(rnd64(), rnd64(), 1'b1, 1'b0, w);
    drop();
    check("align_err_set", 64'(frame_err), 64'd1);
    idle(5);
    check("align_err_held", 64'(frame_err), 64'd1);
    err_clr = 1'b1;
    @(posedge s00_axis_aclk);
    #1;
    err_clr = 1'b0;
    check("align_err_cleared", 64'(frame_err), 64'd0);
    err_clr = 1'b1;
    send(rnd64(), rnd64(), 1'b1, 1'b0, w);
    err_clr = 1'b0;
    drop();
    check("align_set_wins", 64'(frame_err), 64'd1);
    err_clr = 1'b1;
    @(posedge s00_axis_aclk);
    #1;
    err_clr = 1'b0;
    for (int i = 0; i < FRAME_LEN; i++)
      send(rnd64(), rnd64(), i == FRAME_LEN - 1, i == FRAME_LEN - 1, w);
    check("align_resync_frame", 64'(frame_err), 64'd0);
    for (int i = 0; i < FRAME_LEN - 1; i++) send(rnd64(), rnd64(), 1'b0, 1'b0, w);
    check("missing_tlast_before", 64'(frame_err), 64'd0);
    send(rnd64(), rnd64(), 1'b0, 1'b0, w);
    drop();
    check("missing_tlast_err", 64'(frame_err), 64'd1);
    err_clr = 1'b1;
    @(posedge s00_axis_aclk);
    #1;
    err_clr = 1'b0;
    wait_drain();

    // Random frame with random gaps and random output backpressure.
    out_cnt  = 0;
    last_cnt = 0;
    rand_rdy = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      send(rnd64(), rnd64(), i == FRAME_LEN - 1, i == FRAME_LEN - 1, w);
    end
    drop();
    rand_rdy = 1'b0;
    @(posedge s00_axis_aclk);
    #2;
    m00_axis_tready = 1'b1;
    wait_drain();
    check("bp_out_count", 64'(out_cnt), 64'(FRAME_LEN));
    check("bp_tlast_count", 64'(last_cnt), 64'd1);
    check("bp_frame_err", 64'(frame_err), 64'd0);

    // Reset mid-frame with three beats in flight.
    for (int i = 0; i < 8; i++) send(rnd64(), rnd64(), 1'b0, 1'b0, w);
    check("pre_reset_tvalid", 64'(m00_axis_tvalid), 64'd1);
    s00_axis_aresetn = 1'b0;
    drop();
    #1;
    check("reset_tvalid", 64'(m00_axis_tvalid), 64'd0);
    check("reset_tdata", m00_axis_tdata, 64'd0);
    repeat (2) @(posedge s00_axis_aclk);
    #1;
    s00_axis_aresetn = 1'b1;
    err_acc = 0;
    repeat (10) begin
      @(negedge s00_axis_aclk);
      if (m00_axis_tvalid) err_acc++;
    end
    check("no_stale_output", 64'(err_acc), 64'd0);
    @(posedge s00_axis_aclk);
    #1;
    for (int i = 0; i < FRAME_LEN; i++)
      send(rnd64(), rnd64(), i == FRAME_LEN - 1, i == FRAME_LEN - 1, w);
    drop();
    check("post_reset_bin0", 64'(frame_err), 64'd0);
    wait_drain();

    check("protocol", 64'(prot_err), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
